// File: rtl/wire_sequencer.sv
// wire_sequencer: game-side source of the wire-cutting challenge.
// A start pulse plays SEQ_LEN pseudo-random colours, each followed by a blank
// (colour 0) gap. The XOR of the shown colours becomes the wire the player
// must cut. The player's cut, or a timeout, is then judged as success or fail.
// Downstream pause logic treats curr_colour == 0 as a pause, so the blank gaps
// double as pause signalling.

module wire_sequencer #(
  parameter int unsigned SEQ_LEN        = 4,              // 1..15 colours per round
  parameter int unsigned ON_CYCLES      = 100_000_000,    // >= 1
  parameter int unsigned GAP_CYCLES     = 25_000_000,     // >= 1
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,  // >= 1
  parameter logic [7:0]  SEED           = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cut_valid,
  input  logic [2:0] cut_wire,
  output logic [2:0] curr_colour,
  output logic [2:0] wire_to_cut,
  output logic       busy,
  output logic       done,
  output logic       success,
  output logic       fail
);

  // FSM encoding
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StShow   = 3'd1;
  localparam logic [2:0] StGap    = 3'd2;
  localparam logic [2:0] StWait   = 3'd3;
  localparam logic [2:0] StResult = 3'd4;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0] SeedInit = (SEED == 8'h00) ? 8'h01 : SEED;

  // Terminal counts: each phase lasts exactly its cycle count, counting 0..N-1.
  localparam logic [31:0] OnLast      = 32'(ON_CYCLES - 1);
  localparam logic [31:0] GapLast     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  IdxLast     = 4'(SEQ_LEN - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [2:0]  acc_q, acc_d;
  logic [2:0]  colour_q, colour_d;
  logic [2:0]  wire_q, wire_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        success_q, success_d;
  logic        fail_q, fail_d;

  logic [7:0]  lfsr_next;
  logic [2:0]  new_colour;
  logic        cut_match;

  // LFSR successor and the colour it yields; colour 0 is reserved for blank.
  always_comb begin
    lfsr_next  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    new_colour = (lfsr_next[2:0] == 3'd0) ? 3'd1 : lfsr_next[2:0];
    cut_match  = (cut_wire == wire_q);
  end

  // Next-state logic for the round FSM, counters and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lfsr_d    = lfsr_q;
    acc_d     = acc_q;
    colour_d  = colour_q;
    wire_d    = wire_q;
    busy_d    = busy_q;
    done_d    = done_q;
    success_d = success_q;
    fail_d    = fail_q;

    case (state_q)
      StIdle, StResult: begin
        if (start) begin
          // Begin a round: the LFSR keeps its state across rounds.
          state_d   = StShow;
          cnt_d     = 32'd0;
          idx_d     = 4'd0;
          lfsr_d    = lfsr_next;
          acc_d     = new_colour;
          colour_d  = new_colour;
          wire_d    = 3'd0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          success_d = 1'b0;
          fail_d    = 1'b0;
        end
      end

      StShow: begin
        if (cnt_q == OnLast) begin
          state_d  = StGap;
          cnt_d    = 32'd0;
          colour_d = 3'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = 32'd0;
          if (idx_q < IdxLast) begin
            state_d  = StShow;
            idx_d    = idx_q + 4'd1;
            lfsr_d   = lfsr_next;
            acc_d    = acc_q ^ new_colour;
            colour_d = new_colour;
          end else begin
            // Target becomes visible on the first WAIT cycle; 0 would read as "none".
            state_d = StWait;
            wire_d  = (acc_q == 3'd0) ? 3'd7 : acc_q;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      StWait: begin
        // A cut on the final timeout cycle still counts as the player's answer.
        if (cut_valid) begin
          state_d   = StResult;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          success_d = cut_match;
          fail_d    = ~cut_match;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StResult;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          success_d = 1'b0;
          fail_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle.
        state_d   = StIdle;
        cnt_d     = 32'd0;
        idx_d     = 4'd0;
        colour_d  = 3'd0;
        wire_d    = 3'd0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        success_d = 1'b0;
        fail_d    = 1'b0;
      end
    endcase
  end

  // State registers; asynchronous reset drops every output without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 32'd0;
      idx_q     <= 4'd0;
      lfsr_q    <= SeedInit;
      acc_q     <= 3'd0;
      colour_q  <= 3'd0;
      wire_q    <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lfsr_q    <= lfsr_d;
      acc_q     <= acc_d;
      colour_q  <= colour_d;
      wire_q    <= wire_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      success_q <= success_d;
      fail_q    <= fail_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    curr_colour = colour_q;
    wire_to_cut = wire_q;
    busy        = busy_q;
    done        = done_q;
    success     = success_q;
    fail        = fail_q;
  end

endmodule

// File: tb/tb_wire_sequencer.sv
// Self-checking bench for wire_sequencer with short timing parameters.
// Expected colour traces go into a scoreboard queue when a round is started
// and are popped and compared cycle by cycle as the DUT plays them.

module tb_wire_sequencer;

  localparam int unsigned SeqLen  = 4;
  localparam int unsigned OnCyc   = 3;
  localparam int unsigned GapCyc  = 2;
  localparam int unsigned ToCyc   = 20;
  localparam logic [7:0]  SeedVal = 8'h01;
  localparam int          RoundCyc = SeqLen * (OnCyc + GapCyc);

  logic       clk;
  logic       rst;
  logic       start;
  logic       cut_valid;
  logic [2:0] cut_wire;
  logic [2:0] curr_colour;
  logic [2:0] wire_to_cut;
  logic       busy;
  logic       done;
  logic       success;
  logic       fail;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_q[$];
  logic [7:0] m_lfsr;
  logic [2:0] exp_wire;
  logic [2:0] spec_cols[4] = '{3'd2, 3'd4, 3'd1, 3'd1};

  wire_sequencer #(
    .SEQ_LEN        (SeqLen),
    .ON_CYCLES      (OnCyc),
    .GAP_CYCLES     (GapCyc),
    .TIMEOUT_CYCLES (ToCyc),
    .SEED           (SeedVal)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cut_valid   (cut_valid),
    .cut_wire    (cut_wire),
    .curr_colour (curr_colour),
    .wire_to_cut (wire_to_cut),
    .busy        (busy),
    .done        (done),
    .success     (success),
    .fail        (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference LFSR step for the expected colour model.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Push one round of expected colours from the reference LFSR.
  task automatic push_model_round();
    logic [2:0] acc;
    logic [2:0] c;
    acc = 3'd0;
    for (int k = 0; k < int'(SeqLen); k++) begin
      m_lfsr = lfsr_step(m_lfsr);
      c = (m_lfsr[2:0] == 3'd0) ? 3'd1 : m_lfsr[2:0];
      acc = acc ^ c;
      for (int j = 0; j < int'(OnCyc); j++) exp_q.push_back(c);
      for (int j = 0; j < int'(GapCyc); j++) exp_q.push_back(3'd0);
    end
    exp_wire = (acc == 3'd0) ? 3'd7 : acc;
  endtask

  // Push the hand-derived first round from seed 0x01 (LFSR 02,04,08,11).
  task automatic push_spec_round();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < int'(OnCyc); j++) exp_q.push_back(spec_cols[k]);
      for (int j = 0; j < int'(GapCyc); j++) exp_q.push_back(3'd0);
    end
    exp_wire = 3'd6;
    m_lfsr   = 8'h11;
  endtask

  // Pulse start, then pop/compare the scoreboard each cycle of the round.
  // inject_at: cycle index at which start and cut_valid are pulsed (-1: none).
  // stop_after: cycle index after which to return early (-1: play to WAIT entry).
  task automatic play_round(input string name, input int inject_at, input int stop_after);
    logic [2:0] e;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < RoundCyc; i++) begin
      if (i > 0) tick();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard empty at cycle %0d", name, i);
      end else begin
        e = exp_q.pop_front();
        if (curr_colour !== e || busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s cycle %0d: colour=%0d busy=%b done=%b, need colour=%0d busy=1 done=0",
                   name, i, curr_colour, busy, done, e);
        end
      end
      if (i == inject_at) begin
        start     = 1'b1;
        cut_valid = 1'b1;
        cut_wire  = 3'd6;
      end else begin
        start     = 1'b0;
        cut_valid = 1'b0;
      end
      if (i == stop_after) return;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    cut_valid = 1'b0;
    cut_wire = 3'd0;
    m_lfsr = SeedVal;
    #1;
    tick();
    tick();
    checks++;
    if ({curr_colour, wire_to_cut, busy, done, success, fail} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: colour=%0d wire=%0d busy=%b done=%b succ=%b fail=%b, need all 0",
               curr_colour, wire_to_cut, busy, done, success, fail);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (curr_colour !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: colour=%0d busy=%b, need 0 0", curr_colour, busy);
    end
  endtask

  task automatic test_sequence_success();
    push_spec_round();
    play_round("seq_first", -1, -1);
    checks++;
    if (wire_to_cut !== 3'd6 || busy !== 1'b1 || curr_colour !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry_first: wire=%0d busy=%b colour=%0d done=%b, need 6 1 0 0",
               wire_to_cut, busy, curr_colour, done);
    end
    cut_wire  = 3'd6;
    cut_valid = 1'b1;
    tick();
    cut_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || success !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 ||
        curr_colour !== 3'd0 || wire_to_cut !== 3'd6) begin
      errors++;
      $display("FAIL cut_success: done=%b succ=%b fail=%b busy=%b colour=%0d wire=%0d, need 1 1 0 0 0 6",
               done, success, fail, busy, curr_colour, wire_to_cut);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || success !== 1'b1 || wire_to_cut !== 3'd6) begin
      errors++;
      $display("FAIL result_hold: done=%b succ=%b wire=%0d, need 1 1 6", done, success, wire_to_cut);
    end
  endtask

  task automatic test_wrong_cut();
    push_model_round();
    play_round("seq_wrong", -1, -1);
    checks++;
    if (wire_to_cut !== exp_wire || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry_wrong: wire=%0d busy=%b, need %0d 1", wire_to_cut, busy, exp_wire);
    end
    cut_wire  = exp_wire ^ 3'd5;
    cut_valid = 1'b1;
    tick();
    cut_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || success !== 1'b0 || fail !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cut_wrong: done=%b succ=%b fail=%b busy=%b, need 1 0 1 0",
               done, success, fail, busy);
    end
  endtask

  task automatic test_timeout();
    push_model_round();
    play_round("seq_timeout", -1, -1);
    for (int i = 1; i < int'(ToCyc); i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || fail !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL timeout_early: %0d cycles into WAIT done=%b fail=%b busy=%b, need 0 0 1",
                 i, done, fail, busy);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || fail !== 1'b1 || success !== 1'b0 || wire_to_cut !== exp_wire) begin
      errors++;
      $display("FAIL timeout_fail: done=%b fail=%b succ=%b wire=%0d, need 1 1 0 %0d",
               done, fail, success, wire_to_cut, exp_wire);
    end
  endtask

  task automatic test_ignored_inputs();
    push_model_round();
    play_round("seq_ignored", 1, -1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || wire_to_cut !== exp_wire) begin
      errors++;
      $display("FAIL ignored_wait_entry: done=%b busy=%b wire=%0d, need 0 1 %0d",
               done, busy, wire_to_cut, exp_wire);
    end
    cut_wire  = exp_wire;
    cut_valid = 1'b1;
    tick();
    cut_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || success !== 1'b1) begin
      errors++;
      $display("FAIL ignored_then_cut: done=%b succ=%b, need 1 1", done, success);
    end
  endtask

  task automatic test_reset_mid_round();
    push_model_round();
    // Cycle 8 is the first cycle of the second gap.
    play_round("seq_pre_reset", -1, 8);
    checks++;
    if (busy !== 1'b1 || curr_colour !== 3'd0) begin
      errors++;
      $display("FAIL in_second_gap: busy=%b colour=%0d, need 1 0", busy, curr_colour);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({curr_colour, wire_to_cut, busy, done, success, fail} !== 10'd0) begin
      errors++;
      $display("FAIL reset_async: colour=%0d wire=%0d busy=%b done=%b succ=%b fail=%b, need all 0",
               curr_colour, wire_to_cut, busy, done, success, fail);
    end
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_lfsr = SeedVal;
    tick();
  endtask

  task automatic test_cut_beats_timeout();
    push_model_round();
    play_round("seq_after_reset", -1, -1);
    checks++;
    if (wire_to_cut !== 3'd6) begin
      errors++;
      $display("FAIL wait_entry_after_reset: wire=%0d, need 6", wire_to_cut);
    end
    for (int i = 1; i < int'(ToCyc); i++) tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL before_last_wait: done=%b, need 0", done);
    end
    cut_wire  = 3'd6;
    cut_valid = 1'b1;
    tick();
    cut_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || success !== 1'b1 || fail !== 1'b0) begin
      errors++;
      $display("FAIL cut_beats_timeout: done=%b succ=%b fail=%b, need 1 1 0", done, success, fail);
    end
    // Second round from RESULT continues the LFSR from 0x11: colours 3,7,6,4.
    push_model_round();
    start = 1'b1;
    checks++;
    if (exp_q[0] !== 3'd3) begin
      errors++;
      $display("FAIL model_continue: first queued colour=%0d, need 3", exp_q[0]);
    end
    play_round("seq_continue", -1, -1);
    checks++;
    if (wire_to_cut !== exp_wire || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry_continue: wire=%0d busy=%b, need %0d 1", wire_to_cut, busy, exp_wire);
    end
  endtask

  initial begin
    test_reset();
    test_sequence_success();
    test_wrong_cut();
    test_timeout();
    test_ignored_inputs();
    test_reset_mid_round();
    test_cut_beats_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wire_sequencer.md
# wire_sequencer

Game-side source of the wire-cutting challenge. On a start pulse it plays a pseudo-random sequence of wire colours on `curr_colour`, with a blank colour 0 shown between colours. It then publishes the wire the player must cut on `wire_to_cut` and judges the player's cut as success or fail. Downstream pause logic treats `curr_colour == 0` as a pause, so this block drives both the colour display and that pause signalling.

## Interface
- `SEQ_LEN`, default 4: number of colours per round, legal range 1..15.
- `ON_CYCLES`, default 100_000_000: cycles each colour is shown, must be ≥1, held in a 32-bit counter.
- `GAP_CYCLES`, default 25_000_000: cycles of blank (colour 0) after each colour, must be ≥1.
- `TIMEOUT_CYCLES`, default 1_000_000_000: cycles allowed in WAIT before an automatic fail, must be ≥1.
- `SEED`, default 8'h01: LFSR reset value; 8'h00 is replaced by 8'h01.
- `clk` in, 1 bit: system clock, everything is on the rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `start` in, 1 bit: single-cycle pulse that begins a round.
- `cut_valid` in, 1 bit: single-cycle pulse, the player has cut `cut_wire`.
- `cut_wire` in, 3 bits: the colour of the wire that was cut.
- `curr_colour` out, 3 bits: colour currently shown, 0 means blank/pause.
- `wire_to_cut` out, 3 bits: the target wire; valid in WAIT and RESULT, 0 otherwise.
- `busy` out, 1 bit: high in SHOW, GAP and WAIT.
- `done` out, 1 bit: high in RESULT.
- `success` out, 1 bit: in RESULT, the cut was correct.
- `fail` out, 1 bit: in RESULT, the cut was wrong or the round timed out.

## Operation
- States are IDLE, SHOW, GAP, WAIT and RESULT. Outputs are registered.
- Reset values:
  - state IDLE.
  - `curr_colour`, `wire_to_cut`, `busy`, `done`, `success`, `fail` all 0.
  - LFSR = SEED; the XOR accumulator and index counter are 0.
- LFSR is 8-bit Fibonacci: `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
  - It advances exactly once per colour, on entry to SHOW.
  - It is never reloaded by `start`, only by `rst`.
- Colour mapping: colour = `next_lfsr[2:0]`, with 0 mapped to 1. `curr_colour` is therefore never 0 in SHOW.
- XOR accumulator: cleared on `start` and XORed with each colour as it enters SHOW.
- IDLE or RESULT, `start`=1:
  - go to SHOW; clear accumulator, index and result flags; `wire_to_cut` = 0.
- SHOW: hold the colour for ON_CYCLES cycles, then go to GAP with `curr_colour` = 0.
- GAP: hold colour 0 for GAP_CYCLES cycles.
  - If index < SEQ_LEN-1, increment the index and go to SHOW (next colour).
  - Otherwise go to WAIT.
- WAIT entry:
  - `wire_to_cut` = accumulator, or 7 if the accumulator is 0.
  - `curr_colour` stays 0; the timeout counter is cleared.
- WAIT with `cut_valid`=1:
  - go to RESULT, with `success` = (`cut_wire` == `wire_to_cut`) and `fail` = its complement.
- WAIT with no cut for TIMEOUT_CYCLES cycles: go to RESULT with `fail`=1.
- RESULT: hold `done`, the result flag and `wire_to_cut` until the next `start`.
- Ignored inputs and priority:
  - `start` is ignored while `busy`.
  - `cut_valid` is ignored outside WAIT.
  - If `cut_valid` arrives on the timeout cycle, the cut wins.
- `rst` mid-round returns to IDLE immediately; outputs drop in the same cycle without waiting for a clock edge.

## Timing
- `start` sampled at edge N: at N+1, state = SHOW, `curr_colour` = first colour, `busy`=1.
- Each colour is visible for exactly ON_CYCLES cycles, followed by exactly GAP_CYCLES cycles of 0.
- WAIT begins at N+1+SEQ_LEN·(ON_CYCLES+GAP_CYCLES); `wire_to_cut` is valid in that same cycle.
- `cut_valid` sampled at edge M in WAIT: at M+1, `done`=1, a flag is set, `busy`=0.
- A timeout fail asserts exactly TIMEOUT_CYCLES cycles after WAIT entry.
- Between colours, the pause indication (`curr_colour`==0) lasts exactly GAP_CYCLES.

## Test plan
- Bench parameters for all scenarios: SEQ_LEN=4, ON=3, GAP=2, TIMEOUT=20, SEED=8'h01.
- Reset, then pulse `start` → `curr_colour` sequence 2,2,2,0,0,4,4,4,0,0,1,1,1,0,0,1,1,1,0,0 (LFSR 02,04,08,11). Then WAIT with `wire_to_cut`=6, `busy`=1.
- In WAIT, `cut_valid` with `cut_wire`=6 → next cycle `done`=1, `success`=1, `fail`=0, `curr_colour`=0.
- Repeat with `cut_wire`=3 → `fail`=1, `success`=0. Send no cut → `fail`=1 exactly 20 cycles after WAIT entry.
- `start` and `cut_valid` pulsed during SHOW → no restart and no result; the sequence timing is unchanged.
- Assert `rst` during the second GAP → all outputs 0 immediately. A following `start` replays colour 2 first (LFSR reloaded to 01).
- `cut_valid` on the 20th WAIT cycle with `cut_wire`=6 → `success`=1 (cut beats timeout). A second `start` from RESULT continues the LFSR from 0x11.
